// File: rtl/ysyx_24100029_demux1to4.sv
// ---------------------------------------------------------------------------
// ysyx_24100029_demux1to4
//
// Handshaked 1-to-4 stream distributor. One valid/ready input stream carries
// a per-beat destination select. Each beat is steered into one of four
// valid/ready output streams. Every output owns a one-entry register slice,
// so a stalled consumer only back-pressures beats addressed to itself. The
// other three ports keep flowing.
//
// Beats with an illegal select are accepted and thrown away. Each dropped
// beat is flagged by a one-cycle err_o pulse and counted in a saturating
// counter. Only the one-hot select encoding has illegal codes.
//
// Parameters:
//   DATA_WIDTH  payload width
//   Is_One_Hot  1: 4-bit one-hot select, 0: 2-bit binary select
//   CNT_WIDTH   width of the dropped-beat counter
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   data_i         input payload
//   sel_i          destination select, qualified by valid_i
//   valid_i        input beat valid
//   ready_o        input beat accepted when valid_i & ready_o
//   data_o0..3     per-port payload (register outputs)
//   valid_o        per-port valid, bit k belongs to port k (register outputs)
//   ready_i        per-port consumer ready
//   err_o          one-cycle pulse after an illegal-select beat is dropped
//   drop_cnt_o     saturating count of dropped beats
// ---------------------------------------------------------------------------
module ysyx_24100029_demux1to4 #(
  parameter int DATA_WIDTH = 32,
  parameter bit Is_One_Hot = 1'b1,
  parameter int CNT_WIDTH  = 8,
  localparam int SEL_WIDTH = Is_One_Hot ? 4 : 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o0,
  output logic [DATA_WIDTH-1:0] data_o1,
  output logic [DATA_WIDTH-1:0] data_o2,
  output logic [DATA_WIDTH-1:0] data_o3,
  output logic [3:0]            valid_o,
  input  logic [3:0]            ready_i,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

  // Decoded destination. sel_idx is only meaningful when sel_legal is set.
  logic       sel_legal;
  logic [1:0] sel_idx;

  // Slot state and next-state values.
  logic [3:0]            full_q, full_d;
  logic [DATA_WIDTH-1:0] slot_data_q [4];
  logic [DATA_WIDTH-1:0] slot_data_d [4];

  // Drop reporting state.
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // Handshake helpers.
  logic       accept;
  logic [3:0] fill;
  logic [3:0] drain;

  // Select decode. In one-hot mode, only a single set bit names a port.
  // Zero and multi-hot codes are illegal. Every binary code is legal.
  if (Is_One_Hot) begin : g_onehot
    always_comb begin
      sel_legal = 1'b1;
      sel_idx   = 2'd0;
      case (sel_i)
        4'b0001: sel_idx = 2'd0;
        4'b0010: sel_idx = 2'd1;
        4'b0100: sel_idx = 2'd2;
        4'b1000: sel_idx = 2'd3;
        default: sel_legal = 1'b0;
      endcase
    end
  end else begin : g_binary
    assign sel_legal = 1'b1;
    assign sel_idx   = sel_i;
  end

  // ready_o only looks at the addressed slot, so one full slot never blocks
  // beats for the other ports. A full slot can still accept a beat while its
  // consumer takes the old one, which gives one beat per cycle per port.
  // Illegal beats are always accepted so they can be dropped. ready_o does
  // not depend on valid_i.
  always_comb begin
    ready_o = 1'b1;
    if (sel_legal) begin
      ready_o = ~full_q[sel_idx] | ready_i[sel_idx];
    end
    accept = valid_i & ready_o;
  end

  // Per-slot fill/drain. When a slot fills and drains in the same cycle,
  // it stays full and takes the new beat.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      fill[k]        = accept & sel_legal & (sel_idx == 2'(k));
      drain[k]       = full_q[k] & ready_i[k];
      full_d[k]      = fill[k] | (full_q[k] & ~drain[k]);
      slot_data_d[k] = fill[k] ? data_i : slot_data_q[k];
    end
  end

  // Drop bookkeeping. err pulses once per dropped beat. The counter stops
  // at all-ones instead of wrapping.
  always_comb begin
    err_d      = accept & ~sel_legal;
    drop_cnt_d = drop_cnt_q;
    if (err_d && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers. Reset has priority over any handshake in the same
  // cycle, so beats accepted during reset are lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q     <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
      for (int k = 0; k < 4; k++) begin
        slot_data_q[k] <= '0;
      end
    end else begin
      full_q     <= full_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
      for (int k = 0; k < 4; k++) begin
        slot_data_q[k] <= slot_data_d[k];
      end
    end
  end

  // All stream outputs come straight from registers.
  assign valid_o    = full_q;
  assign data_o0    = slot_data_q[0];
  assign data_o1    = slot_data_q[1];
  assign data_o2    = slot_data_q[2];
  assign data_o3    = slot_data_q[3];
  assign err_o      = err_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
